// File: rtl/lpffir_sym_pipe_pkg.sv
// lpffir_pkg: shared constants and helpers for the symmetric FIR pipeline.
//   LPFFIR_LATENCY     accept-to-output latency in cycles when not stalled
//   NTAPS_D/DW_D/CW_D  default tap count, sample width, coefficient width
//   acc_width()        accumulator width of the adder tree
//   sat_rnd()          round-half-up right shift followed by clamping to dw bits
package lpffir_pkg;

    localparam int LPFFIR_LATENCY = 5;
    localparam int NTAPS_D        = 6;
    localparam int DW_D           = 16;
    localparam int CW_D           = 8;

    typedef struct packed {
        logic signed [63:0] val;
        logic               sat;
    } sat_rnd_t;

    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + 1 + $clog2(ntaps / 2);
    endfunction

    // The sum is carried in 64 bits so the helper serves any parameter set.
    function automatic sat_rnd_t sat_rnd(input logic signed [63:0] sum,
                                         input int shift, input int dw);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_rnd_t           res;
        if (shift > 0) begin
            r = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            r = sum;
        end
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        res.val = r;
        res.sat = 1'b0;
        if (r > hi) begin
            res.val = hi;
            res.sat = 1'b1;
        end else if (r < lo) begin
            res.val = lo;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lpffir_sym_pipe_if.sv
// lpffir_sym_pipe_if: sample stream in and filtered stream out, valid/ready.
//   x_i, x_valid_i, x_ready_o   input sample handshake
//   y_o, y_valid_o, y_ready_i   output sample handshake
//   slave  : filter side      master : source/sink side
interface lpffir_sym_pipe_if
    import lpffir_pkg::*;
#(
    parameter int DW = DW_D
) ();

    logic [DW-1:0] x_i;
    logic          x_valid_i;
    logic          x_ready_o;
    logic [DW-1:0] y_o;
    logic          y_valid_o;
    logic          y_ready_i;

    modport slave (
        input  x_i, x_valid_i, y_ready_i,
        output x_ready_o, y_o, y_valid_o
    );

    modport master (
        output x_i, x_valid_i, y_ready_i,
        input  x_ready_o, y_o, y_valid_o
    );

endinterface

// File: rtl/lpffir_sym_pipe_preadd.sv
// lpffir_preadd: registered symmetric pre-adder, NTAPS/2 lanes.
//   clk_i, rstn_i   clock, synchronous active-low reset
//   flush_i         clears the stage valid
//   adv_i           stage may load (pipeline not stalled)
//   d_i, v_i        delay line taps and their valid
//   p_o, v_o        p[j] = d[j] + d[NTAPS-1-j] (DW+1 bits) and its valid
module lpffir_preadd
    import lpffir_pkg::*;
#(
    parameter int NTAPS = NTAPS_D,
    parameter int DW    = DW_D
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic                       adv_i,
    input  logic                       v_i,
    input  logic [NTAPS-1:0][DW-1:0]   d_i,
    output logic [NTAPS/2-1:0][DW:0]   p_o,
    output logic                       v_o
);

    localparam int NH = NTAPS / 2;

    logic [NH-1:0][DW:0] p_d, p_q;
    logic                v_d, v_q;

    always_comb begin
        p_d = p_q;
        v_d = v_q;
        if (adv_i) begin
            v_d = v_i;
            for (int j = 0; j < NH; j++) begin
                p_d[j] = {d_i[j][DW-1], d_i[j]} +
                         {d_i[NTAPS-1-j][DW-1], d_i[NTAPS-1-j]};
            end
        end
        if (flush_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            p_q <= '0;
            v_q <= 1'b0;
        end else begin
            p_q <= p_d;
            v_q <= v_d;
        end
    end

    assign p_o = p_q;
    assign v_o = v_q;

endmodule

// File: rtl/lpffir_sym_pipe.sv
// lpffir_sym_pipe: pipelined linear-phase FIR with symmetric pre-add,
// signed coefficients, rounding right shift and output saturation.
//   clk_i, rstn_i   clock, synchronous active-low reset
//   en_i            0 stops accepting samples; the pipeline still drains
//   flush_i         clears delay line, stage valids and sat_o
//   bus (slave)     x_i/x_valid_i/x_ready_o in, y_o/y_valid_o/y_ready_i out
//   sat_o           sticky: some output was clamped
// Build option LPFFIR_COEF_PROG_EN adds coef_we_i/coef_addr_i/coef_data_i and a
// coefficient register file (reset value 1); without it every coefficient is 1.
// Pipeline: delay line -> S1 pre-add -> S2 multiply -> S3 sum -> S4 round/clamp.
module lpffir_sym_pipe
    import lpffir_pkg::*;
#(
    parameter int NTAPS = NTAPS_D,
    parameter int DW    = DW_D,
    parameter int CW    = CW_D,
    parameter int SHIFT = 0
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          en_i,
    input  logic                          flush_i,
    lpffir_sym_pipe_if.slave              bus,
    output logic                          sat_o
`ifdef LPFFIR_COEF_PROG_EN
    ,
    input  logic                          coef_we_i,
    input  logic [$clog2(NTAPS/2)-1:0]    coef_addr_i,
    input  logic [CW-1:0]                 coef_data_i
`endif
);

    localparam int NH   = NTAPS / 2;
    localparam int MW   = DW + CW + 1;
    localparam int ACCW = acc_width(DW, CW, NTAPS);

    logic                      adv, x_ready, accept;
    logic [NTAPS-1:0][DW-1:0]  d_d, d_q;
    logic                      v0_d, v0_q;
    logic [NH-1:0][DW:0]       p;
    logic                      v1;
    logic [NH-1:0][MW-1:0]     m_d, m_q;
    logic                      v2_d, v2_q;
    logic signed [ACCW-1:0]    acc_d, acc_q;
    logic                      v3_d, v3_q;
    logic [DW-1:0]             y_d, y_q;
    logic                      y_valid_d, y_valid_q;
    logic                      sat_d, sat_q;
    logic [NH-1:0][CW-1:0]     coef;
    sat_rnd_t                  rnd;
    logic                      unused_rnd_hi;

`ifdef LPFFIR_COEF_PROG_EN
    logic [NH-1:0][CW-1:0] coef_d, coef_q;

    // Out-of-range addresses match no lane and are dropped.
    always_comb begin
        coef_d = coef_q;
        if (coef_we_i) begin
            for (int j = 0; j < NH; j++) begin
                if (32'(coef_addr_i) == j) begin
                    coef_d[j] = coef_data_i;
                end
            end
        end
    end

    // Coefficients survive flush; only reset returns them to 1.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            coef_q <= {NH{CW'(1)}};
        end else begin
            coef_q <= coef_d;
        end
    end

    assign coef = coef_q;
`else
    assign coef = {NH{CW'(1)}};
`endif

    lpffir_preadd #(
        .NTAPS (NTAPS),
        .DW    (DW)
    ) u_preadd (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (flush_i),
        .adv_i   (adv),
        .v_i     (v0_q),
        .d_i     (d_q),
        .p_o     (p),
        .v_o     (v1)
    );

    always_comb begin
        // A held output blocks every stage, so the whole pipe moves as one.
        adv     = !(y_valid_q && !bus.y_ready_i);
        x_ready = en_i && adv && !flush_i && rstn_i;
        accept  = bus.x_valid_i && x_ready;

        d_d       = d_q;
        v0_d      = v0_q;
        m_d       = m_q;
        v2_d      = v2_q;
        acc_d     = acc_q;
        v3_d      = v3_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        sat_d     = sat_q;
        rnd       = sat_rnd(64'(acc_q), SHIFT, DW);

        if (accept) begin
            d_d = {d_q[NTAPS-2:0], bus.x_i};
        end

        if (adv) begin
            v0_d = accept;
            v2_d = v1;
            for (int j = 0; j < NH; j++) begin
                m_d[j] = MW'($signed(p[j])) * MW'($signed(coef[j]));
            end
            v3_d  = v2_q;
            acc_d = '0;
            for (int j = 0; j < NH; j++) begin
                acc_d = acc_d + ACCW'($signed(m_q[j]));
            end
            y_valid_d = v3_q;
            // Bubbles carry stale data; only real results may touch y or sat.
            if (v3_q) begin
                y_d   = rnd.val[DW-1:0];
                sat_d = sat_q | rnd.sat;
            end
        end

        if (flush_i) begin
            d_d       = '0;
            v0_d      = 1'b0;
            v2_d      = 1'b0;
            v3_d      = 1'b0;
            y_valid_d = 1'b0;
            sat_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            d_q       <= '0;
            v0_q      <= 1'b0;
            m_q       <= '0;
            v2_q      <= 1'b0;
            acc_q     <= '0;
            v3_q      <= 1'b0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            d_q       <= d_d;
            v0_q      <= v0_d;
            m_q       <= m_d;
            v2_q      <= v2_d;
            acc_q     <= acc_d;
            v3_q      <= v3_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            sat_q     <= sat_d;
        end
    end

    assign unused_rnd_hi = ^rnd.val[63:DW];

    assign bus.x_ready_o = x_ready;
    assign bus.y_o       = y_q;
    assign bus.y_valid_o = y_valid_q;
    assign sat_o         = sat_q;

endmodule

// File: tb/tb_lpffir_sym_pipe.sv
// tb_lpffir_sym_pipe: directed vectors with hand-computed outputs for the
// 6-tap, 16-bit filter; a second instance with SHIFT=1 shares the same stimulus.
module tb_lpffir_sym_pipe;
    import lpffir_pkg::*;

    localparam int NTAPS = 6;
    localparam int DW    = 16;
    localparam int CW    = 8;

    logic clk_i = 1'b0;
    logic rstn_i;
    logic en_i;
    logic flush_i;
    logic sat_o;
    logic sat2_o;
`ifdef LPFFIR_COEF_PROG_EN
    logic          coef_we_i;
    logic [1:0]    coef_addr_i;
    logic [CW-1:0] coef_data_i;
`endif

    lpffir_sym_pipe_if #(.DW(DW)) bus ();
    lpffir_sym_pipe_if #(.DW(DW)) bus2 ();

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int got_q[$];
    int got2_q[$];
    int stim[$];
    int expv[$];

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    lpffir_sym_pipe #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .SHIFT(0)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .en_i    (en_i),
        .flush_i (flush_i),
        .bus     (bus),
        .sat_o   (sat_o)
`ifdef LPFFIR_COEF_PROG_EN
        ,
        .coef_we_i   (coef_we_i),
        .coef_addr_i (coef_addr_i),
        .coef_data_i (coef_data_i)
`endif
    );

    lpffir_sym_pipe #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .SHIFT(1)) dut_sh1 (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .en_i    (en_i),
        .flush_i (flush_i),
        .bus     (bus2),
        .sat_o   (sat2_o)
`ifdef LPFFIR_COEF_PROG_EN
        ,
        .coef_we_i   (coef_we_i),
        .coef_addr_i (coef_addr_i),
        .coef_data_i (coef_data_i)
`endif
    );

    assign bus2.x_i       = bus.x_i;
    assign bus2.x_valid_i = bus.x_valid_i;
    assign bus2.y_ready_i = bus.y_ready_i;

    always @(negedge clk_i) begin
        if (bus.y_valid_o && bus.y_ready_i) got_q.push_back(int'($signed(bus.y_o)));
        if (bus2.y_valid_o && bus2.y_ready_i) got2_q.push_back(int'($signed(bus2.y_o)));
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rstn_i        = 1'b0;
        flush_i       = 1'b0;
        bus.x_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        got_q.delete();
        got2_q.delete();
    endtask

    task automatic send(input int v);
        int t = 0;
        bus.x_i       = DW'(v);
        bus.x_valid_i = 1'b1;
        @(negedge clk_i);
        while (!bus.x_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        if (!bus.x_ready_o) check_val("send_ready", int'(bus.x_ready_o), 1);
        acc_cyc = cyc;
        @(posedge clk_i);
        #1 bus.x_valid_i = 1'b0;
    endtask

    task automatic send_all();
        foreach (stim[i]) send(stim[i]);
    endtask

    task automatic cmp_out(input string tag);
        int t = 0;
        while (got_q.size() < expv.size() && t < 200) begin
            @(negedge clk_i);
            #1 t++;
        end
        repeat (8) @(negedge clk_i);
        #1;
        check_val({tag, "_cnt"}, got_q.size(), expv.size());
        foreach (expv[i]) begin
            check_val($sformatf("%s_%0d", tag, i),
                      (i < got_q.size()) ? got_q[i] : -999999, expv[i]);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n0;
        int seen;
        rstn_i        = 1'b0;
        en_i          = 1'b1;
        flush_i       = 1'b0;
        bus.x_i       = '0;
        bus.x_valid_i = 1'b0;
        bus.y_ready_i = 1'b1;
`ifdef LPFFIR_COEF_PROG_EN
        coef_we_i   = 1'b0;
        coef_addr_i = '0;
        coef_data_i = '0;
`endif

        // reset state and enable gating
        do_reset();
        @(negedge clk_i);
        check_val("rst_y_valid", int'(bus.y_valid_o), 0);
        check_val("rst_y", int'($signed(bus.y_o)), 0);
        check_val("rst_sat", int'(sat_o), 0);
        check_val("rst_x_ready", int'(bus.x_ready_o), 1);
        en_i = 1'b0;
        #1 check_val("en_off_ready", int'(bus.x_ready_o), 0);
        en_i = 1'b1;
        @(posedge clk_i);
        #1;

        // impulse: latency, valid drop after handshake, zero history
        send(1);
        t = 0;
        do begin
            @(negedge clk_i);
            t++;
        end while (!bus.y_valid_o && t < 20);
        check_val("latency", cyc - acc_cyc, 5);
        @(negedge clk_i);
        check_val("valid_drop", int'(bus.y_valid_o), 0);
        @(posedge clk_i);
        #1;
        stim = '{0, 0, 0, 0, 0, 0, 0};
        send_all();
        expv = '{1, 1, 1, 1, 1, 1, 0, 0};
        cmp_out("impulse");

        // step of 100
        do_reset();
        stim = '{100, 100, 100, 100, 100, 100, 100};
        send_all();
        expv = '{100, 200, 300, 400, 500, 600, 600};
        cmp_out("step");
        check_val("step_sat", int'(sat_o), 0);

        // positive and negative saturation
        do_reset();
        stim = '{28672, 28672, 28672};
        send_all();
        expv = '{28672, 32767, 32767};
        cmp_out("cpos");
        check_val("cpos_sat", int'(sat_o), 1);

        do_reset();
        check_val("rst_clears_sat", int'(sat_o), 0);
        stim = '{-28672, -28672, -28672};
        send_all();
        expv = '{-28672, -32768, -32768};
        cmp_out("cneg");
        check_val("cneg_sat", int'(sat_o), 1);

        // downstream stall for 3 cycles
        do_reset();
        bus.y_ready_i = 1'b0;
        stim = '{1, 2, 3, 4, 5, 6, 7, 8};
        expv = '{1, 3, 6, 10, 15, 21, 27, 33};
        fork
            send_all();
            begin
                t = 0;
                do begin
                    @(negedge clk_i);
                    t++;
                end while (!bus.y_valid_o && t < 30);
                check_val("stall_y0", int'($signed(bus.y_o)), 1);
                repeat (2) begin
                    @(negedge clk_i);
                    check_val("stall_hold_y", int'($signed(bus.y_o)), 1);
                    check_val("stall_hold_v", int'(bus.y_valid_o), 1);
                    check_val("stall_x_ready", int'(bus.x_ready_o), 0);
                end
                @(posedge clk_i);
                #1 bus.y_ready_i = 1'b1;
            end
        join
        cmp_out("stall");

        // flush mid-stream with a sample offered
        do_reset();
        stim = '{28672, 28672, 28672, 28672, 28672, 28672, 28672, 28672};
        send_all();
        bus.x_i       = 16'h1234;
        bus.x_valid_i = 1'b1;
        flush_i       = 1'b1;
        @(negedge clk_i);
        check_val("flush_x_ready", int'(bus.x_ready_o), 0);
        check_val("flush_sat_before", int'(sat_o), 1);
        check_val("flush_valid_before", int'(bus.y_valid_o), 1);
        @(posedge clk_i);
        #1;
        flush_i       = 1'b0;
        bus.x_valid_i = 1'b0;
        @(negedge clk_i);
        check_val("flush_y_valid", int'(bus.y_valid_o), 0);
        check_val("flush_sat", int'(sat_o), 0);
        #1 n0 = got_q.size();
        repeat (10) @(negedge clk_i);
        #1 check_val("flush_no_out", got_q.size(), n0);
        @(posedge clk_i);
        #1 got_q.delete();
        stim = '{1, 0, 0, 0, 0, 0, 0};
        send_all();
        expv = '{1, 1, 1, 1, 1, 1, 0};
        cmp_out("post_flush");

        // rounding shift on the SHIFT=1 instance
        do_reset();
        stim = '{-3, 0, 0, 0, 0, 0};
        send_all();
        expv = '{-3, -3, -3, -3, -3, -3};
        cmp_out("shift0");
        check_val("shift1_cnt", got2_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("shift1_%0d", i),
                      (i < got2_q.size()) ? got2_q[i] : -999999, -1);
        end
        check_val("shift1_sat", int'(sat2_o), 0);

        // reset while samples are in flight
        do_reset();
        stim = '{5, 6, 7};
        send_all();
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1 rstn_i = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk_i);
            seen = seen | int'(bus.y_valid_o);
        end
        check_val("rst_mid_no_valid", seen, 0);
        @(posedge clk_i);
        #1;

`ifdef LPFFIR_COEF_PROG_EN
        // programmed c[0]=2; address 3 does not exist
        do_reset();
        coef_we_i   = 1'b1;
        coef_addr_i = 2'd0;
        coef_data_i = 8'd2;
        @(posedge clk_i);
        #1;
        coef_addr_i = 2'd3;
        coef_data_i = 8'd5;
        @(posedge clk_i);
        #1 coef_we_i = 1'b0;
        stim = '{1, 0, 0, 0, 0, 0, 0};
        send_all();
        expv = '{2, 1, 1, 1, 1, 2, 0};
        cmp_out("coef");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
